// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer: drives the core's 35-bit instruction word for one tile.
// For each of the nine kernel positions it loads weights, waits a settle gap,
// streams activations, executes, and drains the OFIFO into pmem. It then runs
// the accumulation pass over the sixteen output pixels.
// Each pipelined consumer (l0_wr, pmem write, acc) is taken from the registered
// word of the previous cycle, so it lands exactly one cycle after its read.
// kij_idx follows the kernel position being worked on. During accumulation it
// tracks the position being read, and it sits at 0 in ACC_CLR and ACC_OUT.
module conv_tile_sequencer #(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int in_w     = 6,
  parameter int k_w      = 3,
  parameter int out_w    = 4,
  parameter int gap_cyc  = 10,
  parameter int W_BASE   = 1024,
  parameter int ADDR_W   = 11,
  parameter int inst_w   = 35
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op_mode_in,
  input  logic              ofifo_valid,
  output logic [inst_w-1:0] inst,
  output logic              acc_clr,
  output logic              out_valid,
  output logic [3:0]        kij_idx,
  output logic              busy,
  output logic              done
);

  // Instruction bit positions
  localparam int B_OP   = 34;
  localparam int B_ACC  = 33;
  localparam int B_PCEN = 32;
  localparam int B_PWEN = 31;
  localparam int PA_HI  = 30;
  localparam int PA_LO  = 20;
  localparam int B_XCEN = 19;
  localparam int XA_HI  = 17;
  localparam int XA_LO  = 7;
  localparam int B_OFRD = 6;
  localparam int B_L0RD = 3;
  localparam int B_L0WR = 2;
  localparam int B_EXEC = 1;
  localparam int B_LOAD = 0;

  localparam logic [inst_w-1:0] IDLE_WORD = inst_w'(35'h1_800C_0000);

  // The phase counter must hold the longest phase
  localparam int MAX_A  = (len_nij > gap_cyc) ? len_nij : gap_cyc;
  localparam int MAX_B  = (col > row) ? col : row;
  localparam int MAX_PH = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_PH + 1);
  localparam int O_W    = $clog2(len_onij + 1);
  localparam int OC_W   = $clog2(out_w + 1);
  localparam int KC_W   = $clog2(k_w + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_RD    = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_GAP     = 4'd3;
  localparam logic [3:0] S_A_RD    = 4'd4;
  localparam logic [3:0] S_EXEC    = 4'd5;
  localparam logic [3:0] S_DRAIN   = 4'd6;
  localparam logic [3:0] S_ACC_CLR = 4'd7;
  localparam logic [3:0] S_ACC_RD  = 4'd8;
  localparam logic [3:0] S_ACC_OUT = 4'd9;

  logic [3:0]        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0]        kij, kij_n;
  logic              op_mode, op_n;
  logic [O_W-1:0]    o_cnt, o_cnt_n;
  logic [OC_W-1:0]   o_col, o_col_n;
  logic [ADDR_W-1:0] o_base, o_base_n;
  logic [KC_W-1:0]   k_col, k_col_n;
  logic [ADDR_W-1:0] k_base, k_base_n;
  logic              done_n;
  logic [inst_w-1:0] inst_n;

  assign kij_idx = kij;

  // Next state and loop counters; o_base/k_base step by in_w so no divide is needed
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    kij_n    = kij;
    op_n     = op_mode;
    o_cnt_n  = o_cnt;
    o_col_n  = o_col;
    o_base_n = o_base;
    k_col_n  = k_col;
    k_base_n = k_base;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_W_RD;
          cnt_n   = '0;
          kij_n   = '0;
          op_n    = op_mode_in;
        end
      end
      S_W_RD: begin
        if (cnt == CNT_W'(col - 1)) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (cnt == CNT_W'(col - 1)) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(gap_cyc - 1)) begin
          state_n = S_A_RD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_A_RD: begin
        if (cnt == CNT_W'(len_nij - 1)) begin
          state_n = S_EXEC;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (cnt == CNT_W'(len_nij - 1)) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // cnt counts OFIFO reads already issued before this cycle's read
        if (inst[B_OFRD]) begin
          if (cnt == CNT_W'(len_nij - 1)) begin
            cnt_n = '0;
            if (kij == 4'(len_kij - 1)) begin
              state_n  = S_ACC_CLR;
              kij_n    = '0;
              o_cnt_n  = '0;
              o_col_n  = '0;
              o_base_n = '0;
              k_col_n  = '0;
              k_base_n = '0;
            end else begin
              state_n = S_W_RD;
              kij_n   = kij + 4'd1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      S_ACC_CLR: begin
        state_n = S_ACC_RD;
      end
      S_ACC_RD: begin
        if (kij == 4'(len_kij - 1)) begin
          state_n  = S_ACC_OUT;
          kij_n    = '0;
          k_col_n  = '0;
          k_base_n = '0;
        end else begin
          kij_n = kij + 4'd1;
          if (k_col == KC_W'(k_w - 1)) begin
            k_col_n  = '0;
            k_base_n = k_base + ADDR_W'(in_w);
          end else begin
            k_col_n = k_col + KC_W'(1);
          end
        end
      end
      S_ACC_OUT: begin
        if (o_cnt == O_W'(len_onij - 1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = S_ACC_CLR;
          o_cnt_n = o_cnt + O_W'(1);
          if (o_col == OC_W'(out_w - 1)) begin
            o_col_n  = '0;
            o_base_n = o_base + ADDR_W'(in_w);
          end else begin
            o_col_n = o_col + OC_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Next instruction word: the state's own bits plus consumers of last cycle's reads
  always_comb begin
    inst_n = IDLE_WORD;
    if (state_n != S_IDLE) inst_n[B_OP] = op_n;
    case (state_n)
      S_W_RD: begin
        inst_n[B_XCEN]      = 1'b0;
        inst_n[XA_HI:XA_LO] = ADDR_W'(W_BASE + 32'(kij_n) * col + 32'(cnt_n));
      end
      S_LOAD: begin
        inst_n[B_L0RD] = 1'b1;
        inst_n[B_LOAD] = 1'b1;
      end
      S_A_RD: begin
        inst_n[B_XCEN]      = 1'b0;
        inst_n[XA_HI:XA_LO] = ADDR_W'(cnt_n);
      end
      S_EXEC: begin
        inst_n[B_L0RD] = 1'b1;
        inst_n[B_EXEC] = 1'b1;
      end
      S_DRAIN: begin
        inst_n[B_OFRD] = ofifo_valid;
      end
      S_ACC_RD: begin
        inst_n[B_PCEN]      = 1'b0;
        inst_n[PA_HI:PA_LO] = ADDR_W'(32'(kij_n) * len_nij + 32'(o_base_n) + 32'(o_col_n)
                                      + 32'(k_base_n) + 32'(k_col_n));
      end
      default: begin
      end
    endcase
    if (state_n != S_IDLE) begin
      if (!inst[B_XCEN]) inst_n[B_L0WR] = 1'b1;
      if (inst[B_OFRD]) begin
        inst_n[B_PCEN]      = 1'b0;
        inst_n[B_PWEN]      = 1'b0;
        inst_n[PA_HI:PA_LO] = ADDR_W'(32'(kij) * len_nij + 32'(cnt));
      end
      if (!inst[B_PCEN] && inst[B_PWEN]) inst_n[B_ACC] = 1'b1;
    end
  end

  // Register state, counters and every output; reset drops straight back to the idle word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      kij       <= '0;
      op_mode   <= 1'b0;
      o_cnt     <= '0;
      o_col     <= '0;
      o_base    <= '0;
      k_col     <= '0;
      k_base    <= '0;
      inst      <= IDLE_WORD;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      kij       <= kij_n;
      op_mode   <= op_n;
      o_cnt     <= o_cnt_n;
      o_col     <= o_col_n;
      o_base    <= o_base_n;
      k_col     <= k_col_n;
      k_base    <= k_base_n;
      inst      <= inst_n;
      acc_clr   <= (state_n == S_ACC_CLR);
      out_valid <= (state_n == S_ACC_OUT);
      busy      <= (state_n != S_IDLE);
      done      <= done_n;
    end
  end

endmodule

// File: doc/conv_tile_sequencer.md
Name: conv_tile_sequencer

Overview:
- Hardware instruction sequencer for the core: produces the 35-bit instruction word cycle by cycle for one input/output tile.
- Runs the 9-step kij loop: kernel into L0, kernel into the PEs, a settle gap, activations into L0, execute, then OFIFO drain into pmem.
- Then runs the accumulation pass over the 16 output pixels.
- Replaces the hand-written instruction stimulus used in the core bench; drives the core's inst input directly.

Parameters:
- col, 8, PE columns; kernel words per kij
- row, 8, PE rows
- len_nij, 36, activation words per tile (6x6)
- len_kij, 9, kernel positions (3x3)
- len_onij, 16, output pixels (4x4)
- in_w, 6, input feature-map width
- k_w, 3, kernel width
- out_w, 4, output feature-map width
- gap_cyc, 10, idle cycles after kernel load
- W_BASE, 1024, xmem base of kernel words; kij k occupies W_BASE+k*col .. +col-1
- ADDR_W, 11, SRAM address width
- inst_w, 35, instruction width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- op_mode_in  in  1  latched on start; driven on inst[34] for the whole run
- ofifo_valid  in  1  from core; OFIFO holds data
- inst  out  35  registered instruction word to core
- acc_clr  out  1  one-cycle pulse; clears the SFP accumulator before each output pixel
- out_valid  out  1  one-cycle pulse; core sfp_out is valid on the next cycle
- kij_idx  out  4  current kij (0..8)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the final ACC_OUT to IDLE transition

Behaviour:
- Instruction bit map: 34 op_mode, 33 acc, 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem, 19 CEN_xmem, 18 WEN_xmem, 17:7 A_xmem, 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load.
- Idle word: CEN/WEN of both memories = 1, all other bits 0, i.e. 35'h1_800C_0000 with op_mode 0.
- Reset (async, reset_n=0): state IDLE, inst = idle word, all counters 0, acc_clr/out_valid/busy/done = 0, kij_idx = 0.
- All outputs are registered; inst reflects the state entered on that edge.
- SRAM reads have 1-cycle latency. Every pipelined consumer is asserted exactly one cycle after its read and is not counted in the phase length:
  - l0_wr after an xmem read
  - pmem write after ofifo_rd
  - acc after a pmem read
- State sequence for each kij:
  - W_RD (col cycles): CEN_xmem=0, WEN_xmem=1, A_xmem = W_BASE + kij*col + n.
  - LOAD (col cycles): l0_rd=1, load=1.
  - GAP (gap_cyc cycles): idle word.
  - A_RD (len_nij cycles): xmem reads at A_xmem 0..len_nij-1.
  - EXEC (len_nij cycles): l0_rd=1, execute=1.
  - DRAIN: ofifo_rd=1 only when ofifo_valid=1; each accepted word is written to pmem at A_pmem = kij*len_nij + m on the next cycle (CEN_pmem=0, WEN_pmem=0). Leaves after len_nij accepted words.
  - DRAIN exit: next kij starts at W_RD; after kij 8, go to ACC_CLR.
- ofifo_valid low during DRAIN: stall with the idle word and no timeout.
- Accumulation, for each output pixel o:
  - ACC_CLR (1 cycle): acc_clr=1.
  - ACC_RD (len_kij cycles): CEN_pmem=0, WEN_pmem=1, A_pmem = kij*len_nij + (o/out_w)*in_w + o%out_w + (kij/k_w)*in_w + kij%k_w.
  - acc=1 on the cycle after each read.
  - ACC_OUT (1 cycle): out_valid=1.
- Address generation uses row/column counters; no dividers.
- After o = len_onij-1: done=1, return to IDLE.
- start outside IDLE: ignored.
- Reset mid-run: immediate IDLE with the idle word; no partial pmem write is completed.
- Address widths: all addresses are truncated to ADDR_W; the defaults never overflow (max 8*36+35 = 323).

Test Plan:
- Reset held, then released with no start → inst = 35'h1_800C_0000, busy = 0 for 100 cycles.
- start with op_mode_in=1, ofifo_valid tied 1 → kij0 W_RD A_xmem 1024..1031; LOAD 8 cycles with l0_rd=load=1; first A_RD cycle exactly 10 cycles after the last LOAD cycle; inst[34]=1 throughout.
- ofifo_valid toggled 1,0,1,0 during DRAIN of kij 2 → exactly 36 pmem writes at addresses 72..107, each one cycle after an ofifo_rd cycle, no write while stalled.
- Accumulation, o=5, kij=4 → A_pmem = 158; o=0 addresses 0,37,74,114,151,188,228,265,302; 16 out_valid pulses, each preceded by acc_clr, then one done pulse.
- start pulsed during EXEC → ignored, sequence unchanged; reset_n dropped mid-DRAIN → inst = idle word in the same cycle, state IDLE, a later start restarts at kij 0.
- Full run with the core plus golden out.txt → all 16 sfp_out words match the file.
